// File: rtl/omsp_spm_violation_log_pkg.sv
// Shared constants and record layout for the SPM violation log peripheral.
// Register offsets, CTRL/STATUS bit positions and the captured record format.
package omsp_spm_violation_log_pkg;

  localparam logic [2:0] SPM_VLOG_CTRL      = 3'd0;
  localparam logic [2:0] SPM_VLOG_STATUS    = 3'd1;
  localparam logic [2:0] SPM_VLOG_HEAD_ID   = 3'd2;
  localparam logic [2:0] SPM_VLOG_HEAD_PREV = 3'd3;
  localparam logic [2:0] SPM_VLOG_HEAD_PC   = 3'd4;
  localparam logic [2:0] SPM_VLOG_HEAD_ADDR = 3'd5;
  localparam logic [2:0] SPM_VLOG_POP       = 3'd6;
  localparam logic [2:0] SPM_VLOG_COUNT     = 3'd7;

  localparam int unsigned CTRL_IRQ_EN  = 0;
  localparam int unsigned CTRL_CLR     = 1;
  localparam int unsigned CTRL_CNT_CLR = 2;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVF       = 2;

  typedef struct packed {
    logic [15:0] cur_id;
    logic [15:0] prev_id;
    logic [15:0] pc;
    logic [15:0] addr;
  } vlog_rec_t;

endpackage

// File: rtl/omsp_spm_violation_log_if.sv
// openMSP430 peripheral-bus bundle between the core (master) and a peripheral (slave).
interface omsp_spm_violation_log_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, output per_din, output per_en, output per_we,
                  input per_dout);
  modport slave  (input per_addr, input per_din, input per_en, input per_we,
                  output per_dout);
endinterface

// File: rtl/omsp_spm_violation_fifo.sv
// Record FIFO with wrap-bit pointers; a pop in the same cycle frees the slot for a push.
module omsp_spm_violation_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     mclk,
  input  logic                     puc_rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             pop_ok, push_ok;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level   = wr_ptr_q - rd_ptr_q;
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    // Clear discards any concurrent push, so it must not flag an overflow either.
    ovf     = ~clr & push & full & ~pop_ok;
    head    = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge mclk) begin
    if (push_ok && !clr) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/omsp_spm_violation_log.sv
// SPM violation logger: captures one record per violation rising edge into a FIFO and
// exposes records, a saturating event count and a level IRQ through a peripheral window.
module omsp_spm_violation_log
  import omsp_spm_violation_log_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [14:0] BASE_ADDR = 15'h0190
) (
  input  logic                           mclk,
  input  logic                           puc_rst,
  input  logic                           violation,
  input  logic [15:0]                    spm_current_id,
  input  logic [15:0]                    spm_prev_id,
  input  logic [15:0]                    prev_pc,
  input  logic [15:0]                    eu_mab,
  omsp_spm_violation_log_if.slave        per_bus,
  output logic                           violation_irq
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic        viol_q, evt;
  logic        irq_en_q, ovf_q;
  logic [15:0] count_q;
  logic        sel, wr, ctrl_wr, clr, cnt_clr, pop;
  logic [2:0]  offset;
  vlog_rec_t   rec_in, head;
  logic [AW:0] level;
  logic        full, empty, ovf_pulse;
  logic [15:0] status;

  always_comb begin
    evt     = violation & ~viol_q;
    sel     = per_bus.per_en & (per_bus.per_addr[13:3] == BASE_ADDR[14:4]);
    offset  = per_bus.per_addr[2:0];
    wr      = sel & (|per_bus.per_we);
    ctrl_wr = wr & (offset == SPM_VLOG_CTRL) & per_bus.per_we[0];
    clr     = ctrl_wr & per_bus.per_din[CTRL_CLR];
    cnt_clr = ctrl_wr & per_bus.per_din[CTRL_CNT_CLR];
    pop     = wr & (offset == SPM_VLOG_POP);
    rec_in  = '{cur_id: spm_current_id, prev_id: spm_prev_id, pc: prev_pc, addr: eu_mab};
  end

  omsp_spm_violation_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .clr     (clr),
    .push    (evt),
    .pop     (pop),
    .din     (rec_in),
    .head    (head),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf_pulse)
  );

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      viol_q   <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      viol_q <= violation;
      if (ctrl_wr) irq_en_q <= per_bus.per_din[CTRL_IRQ_EN];
      if (clr)            ovf_q <= 1'b0;
      else if (ovf_pulse) ovf_q <= 1'b1;
      if (cnt_clr)                       count_q <= '0;
      else if (evt && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    status                 = '0;
    status[STAT_NOT_EMPTY] = ~empty;
    status[STAT_FULL]      = full;
    status[STAT_OVF]       = ovf_q;
    status[8:4]            = 5'(level);
  end

  always_comb begin
    per_bus.per_dout = '0;
    if (sel) begin
      case (offset)
        SPM_VLOG_CTRL:      per_bus.per_dout = {15'd0, irq_en_q};
        SPM_VLOG_STATUS:    per_bus.per_dout = status;
        SPM_VLOG_HEAD_ID:   per_bus.per_dout = empty ? 16'd0 : head.cur_id;
        SPM_VLOG_HEAD_PREV: per_bus.per_dout = empty ? 16'd0 : head.prev_id;
        SPM_VLOG_HEAD_PC:   per_bus.per_dout = empty ? 16'd0 : head.pc;
        SPM_VLOG_HEAD_ADDR: per_bus.per_dout = empty ? 16'd0 : head.addr;
        SPM_VLOG_COUNT:     per_bus.per_dout = count_q;
        default:            per_bus.per_dout = '0;
      endcase
    end
  end

  assign violation_irq = irq_en_q & ~empty;

endmodule
